// File: rtl/inst_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
package pipeline_types;

  localparam int IB_DEPTH      = 32;
  localparam int DECODER_WIDTH = 2;

  // One buffered instruction: 113 bits.
  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     inst;
    logic            pre_taken;
    logic [31:0]     pre_addr;
    logic [1:0]      is_exception;
    logic [1:0][6:0] exception_cause;
  } ib_entry_t;

endpackage

// File: rtl/inst_queue_ram.sv
// Two-write / two-read entry storage; synchronous write, combinational read of a
// consecutive pair starting at raddr_i (wrapping modulo DEPTH).
module inst_queue_ram
  import pipeline_types::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic [1:0]          we_i,
  input  logic [1:0][AW-1:0]  waddr_i,
  input  ib_entry_t [1:0]     wdata_i,
  input  logic [AW-1:0]       raddr_i,
  output ib_entry_t [1:0]     rdata_o
);

  ib_entry_t mem_q [DEPTH];

  // The two write addresses are always distinct (wptr, wptr+1).
  always_ff @(posedge clk) begin
    if (we_i[0]) mem_q[waddr_i[0]] <= wdata_i[0];
    if (we_i[1]) mem_q[waddr_i[1]] <= wdata_i[1];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign rdata_o[gi] = mem_q[raddr_i + AW'(gi)];
  end

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode circular instruction queue: up to two pushes and two pops per
// cycle, registered head pair on the decoder bundle, flush on redirect.
module inst_queue
  import pipeline_types::ib_entry_t;
#(
  parameter int IB_DEPTH      = pipeline_types::IB_DEPTH,
  parameter int DECODER_WIDTH = pipeline_types::DECODER_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DECODER_WIDTH-1:0]            fetch_valid,
  input  logic [DECODER_WIDTH-1:0][31:0]      fetch_pc,
  input  logic [DECODER_WIDTH-1:0][31:0]      fetch_inst,
  input  logic [DECODER_WIDTH-1:0]            fetch_pre_taken,
  input  logic [DECODER_WIDTH-1:0][31:0]      fetch_pre_addr,
  input  logic [DECODER_WIDTH-1:0][1:0]       fetch_is_exception,
  input  logic [DECODER_WIDTH-1:0][1:0][6:0]  fetch_exception_cause,
  input  logic                                pause_decoder,
  input  logic                                flush,
  output logic                                pause_buffer,
  output logic [DECODER_WIDTH-1:0][31:0]      pc,
  output logic [DECODER_WIDTH-1:0][31:0]      inst,
  output logic [DECODER_WIDTH-1:0]            valid,
  output logic [DECODER_WIDTH-1:0]            pre_is_branch_taken,
  output logic [DECODER_WIDTH-1:0][31:0]      pre_branch_addr,
  output logic [DECODER_WIDTH-1:0][1:0]       is_exception,
  output logic [DECODER_WIDTH-1:0][1:0][6:0]  exception_cause
);

  localparam int AW = $clog2(IB_DEPTH);

  logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]        count_q, count_d, free;
  logic [1:0]         push_n, pop_n;
  logic               push_ok, pop_ok;
  logic [1:0]         wr_en, valid_q, valid_d;
  logic [1:0][AW-1:0] wr_addr;
  ib_entry_t [1:0]    fetch_entry, wr_data, rd_data, out_q, out_d;

  for (genvar gi = 0; gi < DECODER_WIDTH; gi++) begin : g_slot
    assign fetch_entry[gi] = '{pc:              fetch_pc[gi],
                               inst:            fetch_inst[gi],
                               pre_taken:       fetch_pre_taken[gi],
                               pre_addr:        fetch_pre_addr[gi],
                               is_exception:    fetch_is_exception[gi],
                               exception_cause: fetch_exception_cause[gi]};
    assign pc[gi]                  = out_q[gi].pc;
    assign inst[gi]                = out_q[gi].inst;
    assign pre_is_branch_taken[gi] = out_q[gi].pre_taken;
    assign pre_branch_addr[gi]     = out_q[gi].pre_addr;
    assign is_exception[gi]        = out_q[gi].is_exception;
    assign exception_cause[gi]     = out_q[gi].exception_cause;
  end

  assign valid = valid_q;

  // The 4-entry margin absorbs the fetch packet already in flight.
  assign free         = (AW+1)'(IB_DEPTH) - count_q;
  assign pause_buffer = (free < (AW+1)'(4));

  assign push_ok = !pause_buffer && !flush;
  assign pop_ok  = !pause_decoder && !flush;

  // Compaction: a lone slot-1 instruction lands at wptr.
  assign wr_en[0]   = push_ok && (fetch_valid != 2'b00);
  assign wr_en[1]   = push_ok && (fetch_valid == 2'b11);
  assign wr_data[0] = fetch_valid[0] ? fetch_entry[0] : fetch_entry[1];
  assign wr_data[1] = fetch_entry[1];
  assign wr_addr[0] = wptr_q;
  assign wr_addr[1] = wptr_q + AW'(1);
  assign push_n     = push_ok ? ({1'b0, fetch_valid[0]} + {1'b0, fetch_valid[1]}) : 2'd0;
  assign pop_n      = !pop_ok ? 2'd0 :
                      (count_q > (AW+1)'(1)) ? 2'd2 : {1'b0, count_q[0]};

  inst_queue_ram #(
    .DEPTH (IB_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rptr_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    wptr_d  = wptr_q + AW'(push_n);
    rptr_d  = rptr_q + AW'(pop_n);
    count_d = count_q + (AW+1)'(push_n) - (AW+1)'(pop_n);
    valid_d = valid_q;
    out_d   = out_q;
    if (pop_ok) begin
      valid_d = {count_q > (AW+1)'(1), count_q != '0};
      out_d   = rd_data;
    end
    // Flush drops any same-cycle push and overrides pause.
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      valid_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 2'b00;
      out_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed table plus corner-case sequences and a scoreboarded random stream for inst_queue.
module tb_inst_queue;

  localparam int IB_DEPTH = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            fetch_valid;
  logic [1:0][31:0]      fetch_pc;
  logic [1:0][31:0]      fetch_inst;
  logic [1:0]            fetch_pre_taken;
  logic [1:0][31:0]      fetch_pre_addr;
  logic [1:0][1:0]       fetch_is_exception;
  logic [1:0][1:0][6:0]  fetch_exception_cause;
  logic                  pause_decoder;
  logic                  flush;
  logic                  pause_buffer;
  logic [1:0][31:0]      pc;
  logic [1:0][31:0]      inst;
  logic [1:0]            valid;
  logic [1:0]            pre_is_branch_taken;
  logic [1:0][31:0]      pre_branch_addr;
  logic [1:0][1:0]       is_exception;
  logic [1:0][1:0][6:0]  exception_cause;

  inst_queue dut (
    .clk                   (clk),
    .rst                   (rst),
    .fetch_valid           (fetch_valid),
    .fetch_pc              (fetch_pc),
    .fetch_inst            (fetch_inst),
    .fetch_pre_taken       (fetch_pre_taken),
    .fetch_pre_addr        (fetch_pre_addr),
    .fetch_is_exception    (fetch_is_exception),
    .fetch_exception_cause (fetch_exception_cause),
    .pause_decoder         (pause_decoder),
    .flush                 (flush),
    .pause_buffer          (pause_buffer),
    .pc                    (pc),
    .inst                  (inst),
    .valid                 (valid),
    .pre_is_branch_taken   (pre_is_branch_taken),
    .pre_branch_addr       (pre_branch_addr),
    .is_exception          (is_exception),
    .exception_cause       (exception_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fv;
    logic [31:0] p0;
    logic [31:0] p1;
    logic        pz;
    logic        fl;
    logic [1:0]  ev;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb[$];
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Side fields are derived from pc so every slot is self-describing.
  function automatic logic [80:0] ef(input logic [31:0] p);
    return {~p, p + 32'h40, p[2], p[3:2], p[8:2], p[15:9]};
  endfunction

  function automatic logic [80:0] act_fields(input int s);
    return {inst[s], pre_branch_addr[s], pre_is_branch_taken[s], is_exception[s], exception_cause[s]};
  endfunction

  task automatic drive(input logic [1:0] fv, input logic [31:0] p0, input logic [31:0] p1,
                       input logic pz, input logic fl);
    logic [1:0][31:0] p;
    p = {p1, p0};
    fetch_valid   = fv;
    pause_decoder = pz;
    flush         = fl;
    for (int s = 0; s < 2; s++) begin
      fetch_pc[s]              = p[s];
      fetch_inst[s]            = ~p[s];
      fetch_pre_taken[s]       = p[s][2];
      fetch_pre_addr[s]        = p[s] + 32'h40;
      fetch_is_exception[s]    = p[s][3:2];
      fetch_exception_cause[s] = {p[s][8:2], p[s][15:9]};
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_slot(input string nm, input int s, input logic [31:0] ep);
    chk($sformatf("%s_pc%0d", nm, s), pc[s], ep);
    chk($sformatf("%s_fields%0d", nm, s), act_fields(s), ef(ep));
  endtask

  initial begin
    int          avail;
    int          exp_n;
    logic [1:0]  fv;
    logic        pz;
    logic [31:0] p0, p1, nxt;

    // PCs are offsets from 0x1c000000.
    tbl.push_back('{2'b11, 32'h1c000000, 32'h1c000004, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0});
    tbl.push_back('{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 2'b11, 32'h1c000000, 32'h1c000004});
    tbl.push_back('{2'b10, 32'hdead0000, 32'h1c000008, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0});
    tbl.push_back('{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 2'b01, 32'h1c000008, 32'h0});
    tbl.push_back('{2'b01, 32'h1c00000c, 32'hdead0004, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0});
    tbl.push_back('{2'b11, 32'h1c000010, 32'h1c000014, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0});
    tbl.push_back('{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 2'b11, 32'h1c00000c, 32'h1c000010});
    tbl.push_back('{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 2'b01, 32'h1c000014, 32'h0});
    tbl.push_back('{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 2'b00, 32'h0, 32'h0});
    tbl.push_back('{2'b11, 32'h1c000018, 32'h1c00001c, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0});
    tbl.push_back('{2'b11, 32'h1c000020, 32'h1c000024, 1'b0, 1'b0, 2'b11, 32'h1c000018, 32'h1c00001c});
    tbl.push_back('{2'b00, 32'h0,        32'h0,        1'b1, 1'b0, 2'b11, 32'h1c000018, 32'h1c00001c});
    tbl.push_back('{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 2'b11, 32'h1c000020, 32'h1c000024});
    tbl.push_back('{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 2'b00, 32'h0, 32'h0});
    tbl.push_back('{2'b11, 32'h1c000028, 32'h1c00002c, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0});
    tbl.push_back('{2'b11, 32'h1c000030, 32'h1c000034, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0});
    tbl.push_back('{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 2'b00, 32'h0, 32'h0});
    tbl.push_back('{2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 2'b00, 32'h0, 32'h0});

    // Reset
    rst = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_valid", valid, 2'b00);
    chk("rst_pc", pc, 64'h0);
    chk("rst_inst", inst, 64'h0);
    chk("rst_pbuf", pause_buffer, 1'b0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].fv, tbl[i].p0, tbl[i].p1, tbl[i].pz, tbl[i].fl);
      step();
      $display("vec %0d: fv=%b pz=%b fl=%b -> valid=%b pc0=%h pc1=%h", i, tbl[i].fv,
               tbl[i].pz, tbl[i].fl, valid, pc[0], pc[1]);
      chk($sformatf("tbl%0d_valid", i), valid, tbl[i].ev);
      chk($sformatf("tbl%0d_pbuf", i), pause_buffer, 1'b0);
      if (tbl[i].ev[0]) chk_slot($sformatf("tbl%0d", i), 0, tbl[i].e0);
      if (tbl[i].ev[1]) chk_slot($sformatf("tbl%0d", i), 1, tbl[i].e1);
    end

    // Fill to the threshold with the decoder paused
    for (int i = 0; i < 15; i++) begin
      drive(2'b11, 32'h1c002000 + 32'(8 * i), 32'h1c002004 + 32'(8 * i), 1'b1, 1'b0);
      step();
      $display("fill %0d: pause_buffer=%b", i, pause_buffer);
      chk($sformatf("fill%0d_pbuf", i), pause_buffer, (i == 14) ? 1'b1 : 1'b0);
    end
    drive(2'b11, 32'h1c00f000, 32'h1c00f004, 1'b1, 1'b0);
    step();
    chk("fill_drop_pbuf", pause_buffer, 1'b1);
    chk("fill_drop_valid", valid, 2'b00);
    for (int i = 0; i < 15; i++) begin
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      $display("drain %0d: valid=%b pc0=%h pc1=%h pbuf=%b", i, valid, pc[0], pc[1], pause_buffer);
      chk($sformatf("drain%0d_valid", i), valid, 2'b11);
      chk_slot($sformatf("drain%0d", i), 0, 32'h1c002000 + 32'(8 * i));
      chk_slot($sformatf("drain%0d", i), 1, 32'h1c002004 + 32'(8 * i));
      chk($sformatf("drain%0d_pbuf", i), pause_buffer, 1'b0);
    end
    step();
    chk("drain_end_valid", valid, 2'b00);

    // Flush at count 10 with a simultaneous push
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, 32'h1c003000 + 32'(8 * i), 32'h1c003004 + 32'(8 * i), 1'b1, 1'b0);
      step();
    end
    drive(2'b11, 32'h1c00e000, 32'h1c00e004, 1'b1, 1'b1);
    step();
    $display("flush: valid=%b pbuf=%b", valid, pause_buffer);
    chk("flush_valid", valid, 2'b00);
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("flush_after_valid", valid, 2'b00);
    drive(2'b11, 32'h1c004000, 32'h1c004004, 1'b0, 1'b0);
    step();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    $display("post-flush: valid=%b pc0=%h pc1=%h", valid, pc[0], pc[1]);
    chk("postflush_valid", valid, 2'b11);
    chk_slot("postflush", 0, 32'h1c004000);
    chk_slot("postflush", 1, 32'h1c004004);
    step();
    chk("postflush_idle_valid", valid, 2'b00);

    // Random stream against a scoreboard; the tail cycles drain the queue.
    nxt = 32'h1c100000;
    for (int k = 0; k < 240; k++) begin
      avail = sb.size();
      chk($sformatf("rnd%0d_pbuf", k), pause_buffer, ((IB_DEPTH - avail) < 4) ? 1'b1 : 1'b0);
      fv = (k < 200) ? 2'($urandom_range(0, 3)) : 2'b00;
      pz = (k < 200) ? ($urandom_range(0, 9) < 4) : 1'b0;
      if ((IB_DEPTH - avail) < 4) fv = 2'b00;
      p0 = 32'hdead0000;
      p1 = 32'hdead0004;
      if (fv[0]) begin p0 = nxt; sb.push_back(nxt); nxt += 4; end
      if (fv[1]) begin p1 = nxt; sb.push_back(nxt); nxt += 4; end
      drive(fv, p0, p1, pz, 1'b0);
      step();
      if (!pz) begin
        exp_n = (avail >= 2) ? 2 : avail;
        $display("rnd %0d: fv=%b valid=%b pc0=%h pc1=%h", k, fv, valid, pc[0], pc[1]);
        chk($sformatf("rnd%0d_valid", k), valid, (exp_n == 2) ? 2'b11 : (exp_n == 1) ? 2'b01 : 2'b00);
        for (int s = 0; s < exp_n; s++) begin
          logic [31:0] ep;
          ep = sb.pop_front();
          chk($sformatf("rnd%0d_pc%0d", k, s), pc[s], ep);
        end
      end
    end
    chk("rnd_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
